// File: rtl/sweep_dir_ctrl.sv
// Direction sequencer that keeps an up/down counter sweeping between latched limits.
// Optional SWEEP_CNT_EN adds a completed-sweep counter output.
module sweep_dir_ctrl #(
  parameter int N     = 16,
  parameter int SWC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     lo_lim,
  input  logic [N-1:0]     hi_lim,
  input  logic [N-1:0]     count,
  output logic             up_or_down,
  output logic             turn,
  output logic             range_err,
  output logic             cfg_err,
  output logic [1:0]       state_o
`ifdef SWEEP_CNT_EN
  ,
  output logic [SWC_W-1:0] sweep_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  logic [1:0]   state_r;
  logic [N-1:0] lo_l_r;
  logic [N-1:0] hi_l_r;
  logic         uod_r;
  logic         turn_r;
  logic         rerr_r;

  logic [1:0]   state_s;
  logic         uod_s;
  logic         turn_s;
  logic         rerr_s;
  logic         latch_s;
  logic         sweep_inc_s;
  logic         valid_s;
  logic [N:0]   lo_plus2_s;
  logic [N-1:0] hi_m1_s;
  logic [N-1:0] lo_p1_s;

  // Compare in N+1 bits so lo_lim near the top of range cannot wrap into validity.
  assign lo_plus2_s = {1'b0, lo_lim} + {{(N-1){1'b0}}, 2'b10};
  assign valid_s    = ({1'b0, hi_lim} >= lo_plus2_s);
  assign hi_m1_s    = hi_l_r - {{(N-1){1'b0}}, 1'b1};
  assign lo_p1_s    = lo_l_r + {{(N-1){1'b0}}, 1'b1};

  assign cfg_err    = (state_r == IDLE) && en && !valid_s;
  assign up_or_down = uod_r;
  assign turn       = turn_r;
  assign range_err  = rerr_r;
  assign state_o    = state_r;

  // Next-state decision: turn one count early since the counter moves on the same edge.
  always_comb begin
    state_s     = state_r;
    uod_s       = uod_r;
    turn_s      = 1'b0;
    rerr_s      = 1'b0;
    latch_s     = 1'b0;
    sweep_inc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && valid_s) begin
          latch_s = 1'b1;
          if (count < hi_lim) begin
            state_s = UP;
            uod_s   = 1'b1;
          end else begin
            state_s = DOWN;
            uod_s   = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      UP: begin
        if (!en) begin
          state_s = IDLE;
        end else if (count >= hi_l_r) begin
          state_s = DOWN;
          uod_s   = 1'b0;
          rerr_s  = 1'b1;
        end else if (count == hi_m1_s) begin
          state_s = DOWN;
          uod_s   = 1'b0;
          turn_s  = 1'b1;
        end else begin
          state_s = UP;
        end
      end
      DOWN: begin
        if (!en) begin
          state_s = IDLE;
        end else if (count <= lo_l_r) begin
          state_s = UP;
          uod_s   = 1'b1;
          rerr_s  = 1'b1;
        end else if (count == lo_p1_s) begin
          state_s     = UP;
          uod_s       = 1'b1;
          turn_s      = 1'b1;
          sweep_inc_s = 1'b1;
        end else begin
          state_s = DOWN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, direction and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      uod_r   <= 1'b1;
      turn_r  <= 1'b0;
      rerr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      uod_r   <= uod_s;
      turn_r  <= turn_s;
      rerr_r  <= rerr_s;
    end
  end

  // Limit window is captured only on IDLE exit, so mid-sweep edits wait for the next start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_l_r <= {N{1'b0}};
      hi_l_r <= {N{1'b0}};
    end else if (latch_s) begin
      lo_l_r <= lo_lim;
      hi_l_r <= hi_lim;
    end
  end

`ifdef SWEEP_CNT_EN
  logic [SWC_W-1:0] sweep_cnt_r;

  // Completed sweeps, counted on DOWN->UP turns only; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sweep_cnt_r <= {SWC_W{1'b0}};
    end else if (sweep_inc_s) begin
      sweep_cnt_r <= sweep_cnt_r + {{(SWC_W-1){1'b0}}, 1'b1};
    end
  end

  assign sweep_cnt = sweep_cnt_r;
`else
  logic unused_s;
  assign unused_s = sweep_inc_s;
`endif

endmodule

// File: tb/tb_sweep_dir_ctrl.sv
// Directed bench for sweep_dir_ctrl with a simple up/down counter closing the loop.
module tb_sweep_dir_ctrl;

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] lo_lim;
  logic [15:0] hi_lim;
  logic [15:0] count;
  logic        up_or_down;
  logic        turn;
  logic        range_err;
  logic        cfg_err;
  logic [1:0]  state_o;
`ifdef SWEEP_CNT_EN
  logic [15:0] sweep_cnt;
`endif

  logic        cnt_run;
  logic        cnt_load;
  logic [15:0] cnt_val;

  int checks = 0;
  int passed = 0;

  sweep_dir_ctrl #(.N(16), .SWC_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .lo_lim     (lo_lim),
    .hi_lim     (hi_lim),
    .count      (count),
    .up_or_down (up_or_down),
    .turn       (turn),
    .range_err  (range_err),
    .cfg_err    (cfg_err),
    .state_o    (state_o)
`ifdef SWEEP_CNT_EN
    ,
    .sweep_cnt  (sweep_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream up/down counter fed by up_or_down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= 16'd0;
    else if (cnt_load) count <= cnt_val;
    else if (cnt_run) count <= up_or_down ? count + 16'd1 : count - 16'd1;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [15:0] lo, input logic [15:0] hi);
    @(negedge clk);
    reset = 1'b0; en = 1'b0; cnt_run = 1'b0; cnt_load = 1'b0; cnt_val = 16'd0;
    lo_lim = lo; hi_lim = hi;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(16'd2, 16'd5);
    checks++; if (state_o !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_o); else passed++;
    checks++; if (up_or_down !== 1'b1) $display("FAIL rst_uod: got %0b want 1", up_or_down); else passed++;
    checks++; if (turn !== 1'b0) $display("FAIL rst_turn: got %0b want 0", turn); else passed++;
    checks++; if (range_err !== 1'b0) $display("FAIL rst_rerr: got %0b want 0", range_err); else passed++;
    checks++; if (cfg_err !== 1'b0) $display("FAIL rst_cfg: got %0b want 0", cfg_err); else passed++;
  endtask

  task automatic test_sweep();
    logic [15:0] exp_cnt  [12] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd4,
                                   16'd3, 16'd2, 16'd3, 16'd4, 16'd5, 16'd4};
    logic        exp_turn [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        exp_uod  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                                   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset(16'd2, 16'd5);
    en = 1'b1; cnt_run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (count !== exp_cnt[i]) $display("FAIL sweep_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]); else passed++;
      checks++; if (turn !== exp_turn[i]) $display("FAIL sweep_turn[%0d]: got %0b want %0b", i, turn, exp_turn[i]); else passed++;
      checks++; if (up_or_down !== exp_uod[i]) $display("FAIL sweep_uod[%0d]: got %0b want %0b", i, up_or_down, exp_uod[i]); else passed++;
      checks++; if (range_err !== 1'b0) $display("FAIL sweep_rerr[%0d]: got %0b want 0", i, range_err); else passed++;
      if (i == 0) begin
        checks++; if (state_o !== 2'd1) $display("FAIL sweep_state_up: got %0d want 1", state_o); else passed++;
      end
    end
  endtask

  task automatic test_cfg_err();
    do_reset(16'd5, 16'd6);
    en = 1'b1;
    #1;
    checks++; if (cfg_err !== 1'b1) $display("FAIL cfg_on: got %0b want 1", cfg_err); else passed++;
    step();
    step();
    checks++; if (state_o !== 2'd0) $display("FAIL cfg_idle: got %0d want 0", state_o); else passed++;
    checks++; if (turn !== 1'b0) $display("FAIL cfg_turn: got %0b want 0", turn); else passed++;
    checks++; if (cfg_err !== 1'b1) $display("FAIL cfg_hold: got %0b want 1", cfg_err); else passed++;
    hi_lim = 16'd7;
    #1;
    checks++; if (cfg_err !== 1'b0) $display("FAIL cfg_clear: got %0b want 0", cfg_err); else passed++;
    step();
    checks++; if (state_o !== 2'd1) $display("FAIL cfg_enter_up: got %0d want 1", state_o); else passed++;
  endtask

  task automatic test_limit_latch();
    do_reset(16'd2, 16'd5);
    en = 1'b1; cnt_run = 1'b1;
    repeat (3) step();
    hi_lim = 16'd3;
    step();
    checks++; if (turn !== 1'b0 || count !== 16'd4) $display("FAIL latch_no_early: got turn=%0b count=%0d want 0/4", turn, count); else passed++;
    step();
    checks++; if (turn !== 1'b1 || count !== 16'd5) $display("FAIL latch_turn5: got turn=%0b count=%0d want 1/5", turn, count); else passed++;
    step();
    en = 1'b0; cnt_run = 1'b0; hi_lim = 16'd4;
    step();
    checks++; if (state_o !== 2'd0 || up_or_down !== 1'b0 || turn !== 1'b0 || range_err !== 1'b0)
      $display("FAIL latch_idle: got st=%0d uod=%0b turn=%0b rerr=%0b want 0/0/0/0", state_o, up_or_down, turn, range_err); else passed++;
    en = 1'b1; cnt_run = 1'b1;
    step();
    checks++; if (state_o !== 2'd2 || count !== 16'd3 || range_err !== 1'b0)
      $display("FAIL latch_down: got st=%0d count=%0d rerr=%0b want 2/3/0", state_o, count, range_err); else passed++;
    step();
    checks++; if (turn !== 1'b1 || state_o !== 2'd1 || count !== 16'd2)
      $display("FAIL latch_lo_turn: got turn=%0b st=%0d count=%0d want 1/1/2", turn, state_o, count); else passed++;
    step();
    checks++; if (turn !== 1'b0 || count !== 16'd3) $display("FAIL latch_mid: got turn=%0b count=%0d want 0/3", turn, count); else passed++;
    step();
    checks++; if (turn !== 1'b1 || state_o !== 2'd2 || count !== 16'd4)
      $display("FAIL latch_hi4_turn: got turn=%0b st=%0d count=%0d want 1/2/4", turn, state_o, count); else passed++;
  endtask

  task automatic test_range_err();
    do_reset(16'd2, 16'd5);
    en = 1'b1; cnt_run = 1'b1;
    repeat (2) step();
    cnt_load = 1'b1; cnt_val = 16'd9;
    step();
    cnt_load = 1'b0;
    step();
    checks++; if (range_err !== 1'b1 || turn !== 1'b0) $display("FAIL rerr_pulse: got rerr=%0b turn=%0b want 1/0", range_err, turn); else passed++;
    checks++; if (up_or_down !== 1'b0 || state_o !== 2'd2 || count !== 16'd10)
      $display("FAIL rerr_dir: got uod=%0b st=%0d count=%0d want 0/2/10", up_or_down, state_o, count); else passed++;
    step();
    checks++; if (range_err !== 1'b0 || count !== 16'd9) $display("FAIL rerr_one_cycle: got rerr=%0b count=%0d want 0/9", range_err, count); else passed++;
    repeat (6) step();
    step();
    checks++; if (turn !== 1'b1 || state_o !== 2'd1 || count !== 16'd2 || range_err !== 1'b0)
      $display("FAIL rerr_recover: got turn=%0b st=%0d count=%0d rerr=%0b want 1/1/2/0", turn, state_o, count, range_err); else passed++;
    cnt_load = 1'b1; cnt_val = 16'd9;
    step();
    cnt_load = 1'b0;
    step();
    checks++; if (range_err !== 1'b1) $display("FAIL rerr_second: got %0b want 1", range_err); else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if (range_err !== 1'b0 || up_or_down !== 1'b1 || state_o !== 2'd0)
      $display("FAIL rerr_async_rst: got rerr=%0b uod=%0b st=%0d want 0/1/0", range_err, up_or_down, state_o); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_en_drop();
    do_reset(16'd2, 16'd5);
    en = 1'b1; cnt_run = 1'b1;
    repeat (4) step();
    en = 1'b0;
    step();
    checks++; if (state_o !== 2'd0 || turn !== 1'b0 || up_or_down !== 1'b1 || range_err !== 1'b0)
      $display("FAIL endrop_idle: got st=%0d turn=%0b uod=%0b rerr=%0b want 0/0/1/0", state_o, turn, up_or_down, range_err); else passed++;
    cnt_run = 1'b0; en = 1'b1;
    step();
    checks++; if (state_o !== 2'd2 || up_or_down !== 1'b0 || count !== 16'd5)
      $display("FAIL endrop_reenter: got st=%0d uod=%0b count=%0d want 2/0/5", state_o, up_or_down, count); else passed++;
    cnt_run = 1'b1;
    repeat (2) step();
    step();
    checks++; if (turn !== 1'b1 || state_o !== 2'd1 || count !== 16'd2)
      $display("FAIL endrop_turn: got turn=%0b st=%0d count=%0d want 1/1/2", turn, state_o, count); else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if (turn !== 1'b0 || state_o !== 2'd0 || up_or_down !== 1'b1)
      $display("FAIL endrop_async_rst: got turn=%0b st=%0d uod=%0b want 0/0/1", turn, state_o, up_or_down); else passed++;
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef SWEEP_CNT_EN
  task automatic test_sweep_cnt();
    do_reset(16'd2, 16'd5);
    en = 1'b1; cnt_run = 1'b1;
    repeat (19) step();
    checks++; if (sweep_cnt !== 16'd2) $display("FAIL swc_two: got %0d want 2", sweep_cnt); else passed++;
    step();
    checks++; if (sweep_cnt !== 16'd3) $display("FAIL swc_three: got %0d want 3", sweep_cnt); else passed++;
    force dut.sweep_cnt_r = 16'hFFFF;
    release dut.sweep_cnt_r;
    repeat (5) step();
    checks++; if (sweep_cnt !== 16'hFFFF) $display("FAIL swc_preload: got %0h want ffff", sweep_cnt); else passed++;
    step();
    checks++; if (sweep_cnt !== 16'd0) $display("FAIL swc_wrap: got %0h want 0", sweep_cnt); else passed++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; en = 1'b0; lo_lim = 16'd0; hi_lim = 16'd0;
    cnt_run = 1'b0; cnt_load = 1'b0; cnt_val = 16'd0;
    test_reset();
    test_sweep();
    test_cfg_err();
    test_limit_latch();
    test_range_err();
    test_en_drop();
`ifdef SWEEP_CNT_EN
    test_sweep_cnt();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
